// File: rtl/instruction_fetcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetcher_pkg : shared FSM encodings and buffer sizing          |
// | Build option: INS_PREFETCH_EN selects a 2-entry buffer (default 1).       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package instruction_fetcher_pkg;

  localparam logic [1:0] IF_IDLE    = 2'd0;
  localparam logic [1:0] IF_REQ     = 2'd1;
  localparam logic [1:0] IF_DISCARD = 2'd2;

`ifdef INS_PREFETCH_EN
  localparam int IF_DEPTH = 2;
`else
  localparam int IF_DEPTH = 1;
`endif

  localparam int IF_CNT_W = $clog2(IF_DEPTH + 1);
  // Pointer kept at least one bit wide so the single-entry build still has a real index
  localparam int IF_PTR_W = (IF_DEPTH > 1) ? $clog2(IF_DEPTH) : 1;

endpackage
`default_nettype wire

// File: rtl/instruction_fetcher_ins_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ins_buffer : circular {pc, ins} buffer with push/pop/clear                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ins_buffer
  import instruction_fetcher_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_pc,
  input  logic [INS_WIDTH-1:0]  i_push_ins,
  input  logic                  i_pop,
  input  logic                  i_clear,
  output logic [IF_CNT_W-1:0]   o_count,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head_pc,
  output logic [INS_WIDTH-1:0]  o_head_ins
);

  localparam int SLOTS = 2 ** IF_PTR_W;

  logic [DATA_WIDTH-1:0] r_pc_mem  [SLOTS];
  logic [INS_WIDTH-1:0]  r_ins_mem [SLOTS];
  logic [IF_PTR_W-1:0]   r_wr_ptr;
  logic [IF_PTR_W-1:0]   r_rd_ptr;
  logic [IF_CNT_W-1:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  function automatic logic [IF_PTR_W-1:0] ptr_inc(input logic [IF_PTR_W-1:0] p);
    return (p == IF_PTR_W'(IF_DEPTH - 1)) ? '0 : p + IF_PTR_W'(1);
  endfunction

  // Clear wins over push and pop: a flushed cycle neither stores nor retires
  assign w_do_push = i_push && !i_clear;
  assign w_do_pop  = i_pop && (r_count != '0) && !i_clear;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + IF_CNT_W'(1);
        2'b01:   r_count <= r_count - IF_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc_mem[r_wr_ptr]  <= i_push_pc;
      r_ins_mem[r_wr_ptr] <= i_push_ins;
    end
  end

  assign o_count    = r_count;
  assign o_valid    = (r_count != '0);
  assign o_head_pc  = o_valid ? r_pc_mem[r_rd_ptr]  : '0;
  assign o_head_ins = o_valid ? r_ins_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/instruction_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetcher : single-outstanding fetch stage feeding the decoder  |
// | Build option: INS_PREFETCH_EN (prefetch while an instruction waits).      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_flush,
  output logic                  o_pc_inc,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [INS_WIDTH-1:0]  i_imem_data,
  output logic                  o_ins_valid,
  output logic [INS_WIDTH-1:0]  o_ins,
  output logic [DATA_WIDTH-1:0] o_ins_pc,
  input  logic                  i_ins_ready
);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_tgt;
  logic                  r_tgt_valid;
  logic                  w_launch;
  logic                  w_use_tgt;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_launch_addr;
  logic [IF_CNT_W-1:0]   w_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IF_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IF_IDLE:    if (w_launch) w_next_state = IF_REQ;
      IF_REQ: begin
        if (i_imem_ack)   w_next_state = IF_IDLE;
        else if (i_flush) w_next_state = IF_DISCARD;
      end
      IF_DISCARD: if (i_imem_ack) w_next_state = IF_IDLE;
      default:    w_next_state = IF_IDLE;
    endcase
  end

  // A jump in the launch cycle overrides a stale saved target: i_pc already is the newest target
  always_comb begin
    w_launch      = !rst && (r_state == IF_IDLE) && (w_count < IF_CNT_W'(IF_DEPTH));
    w_use_tgt     = r_tgt_valid && !i_flush;
    w_launch_addr = w_use_tgt ? r_tgt : i_pc;
    o_pc_inc      = w_launch && !w_use_tgt;
    w_push        = (r_state == IF_REQ) && i_imem_ack && !i_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_tgt       <= '0;
      r_tgt_valid <= 1'b0;
    end else begin
      r_req <= (w_next_state != IF_IDLE);
      if (w_launch) begin
        r_addr      <= w_launch_addr;
        r_tgt_valid <= 1'b0;
      end else if (i_flush) begin
        r_tgt       <= i_pc;
        r_tgt_valid <= 1'b1;
      end
    end
  end

  assign o_imem_req  = r_req;
  assign o_imem_addr = r_addr;

  ins_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .INS_WIDTH  (INS_WIDTH)
  ) u_ins_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_pc  (r_addr),
    .i_push_ins (i_imem_data),
    .i_pop      (i_ins_ready),
    .i_clear    (i_flush),
    .o_count    (w_count),
    .o_valid    (o_ins_valid),
    .o_head_pc  (o_ins_pc),
    .o_head_ins (o_ins)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
`default_nettype none
// Bench for instruction_fetcher: directed scenarios plus randomized run against a
// program-order model (delivered PCs run sequentially and restart at each jump target).
module tb_instruction_fetcher;

`ifdef INS_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam bit PF = (DEPTH == 2);

  logic       clk;
  logic       rst;
  logic [7:0] i_pc;
  logic       i_flush;
  logic       o_pc_inc;
  logic       o_imem_req;
  logic [7:0] o_imem_addr;
  logic       i_imem_ack;
  logic [7:0] i_imem_data;
  logic       o_ins_valid;
  logic [7:0] o_ins;
  logic [7:0] o_ins_pc;
  logic       i_ins_ready;

  int checks = 0;
  int failures = 0;

  logic [7:0] calc_pc;
  logic [7:0] calc_start;
  int         wait_cnt;
  int         mem_lat;
  bit         mem_rand;
  bit         late_ack;

  instruction_fetcher #(.DATA_WIDTH(8), .INS_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pc        (i_pc),
    .i_flush     (i_flush),
    .o_pc_inc    (o_pc_inc),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_data (i_imem_data),
    .o_ins_valid (o_ins_valid),
    .o_ins       (o_ins),
    .o_ins_pc    (o_ins_pc),
    .i_ins_ready (i_ins_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address 0x10 holds 0xA5
  function automatic logic [7:0] memf(input logic [7:0] a);
    return ((a ^ 8'h10) * 8'h3B) + 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, let combinational outputs settle, step the PC calculator
  task automatic cyc(input logic r, input logic f, input logic [7:0] t, input logic rdy);
    @(negedge clk);
    rst         = r;
    i_flush     = f;
    i_ins_ready = rdy;
    i_pc        = f ? t : calc_pc;
    if (r || !o_imem_req) begin
      i_imem_ack  = 1'b0;
      i_imem_data = 8'h00;
      wait_cnt    = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
    end else if (wait_cnt == 0) begin
      i_imem_ack  = 1'b1;
      i_imem_data = memf(o_imem_addr);
    end else begin
      i_imem_ack  = 1'b0;
      i_imem_data = 8'h00;
      wait_cnt--;
    end
    if (late_ack) begin
      i_imem_ack  = 1'b1;
      i_imem_data = 8'hEE;
    end
    #1;
    if (r)                     calc_pc = calc_start;
    else if (f || o_pc_inc)    calc_pc = i_pc + 8'h01;
  endtask

  task automatic do_reset(input logic [7:0] start);
    calc_start = start;
    calc_pc    = start;
    late_ack   = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_req",    o_imem_req,  0);
    chk("rst_addr",   o_imem_addr, 0);
    chk("rst_valid",  o_ins_valid, 0);
    chk("rst_ins",    o_ins,       0);
    chk("rst_ins_pc", o_ins_pc,    0);
    chk("rst_pc_inc", o_pc_inc,    0);
  endtask

  initial begin
    logic [7:0] exp_pc;
    logic [7:0] tgt;
    logic       fl;
    logic       rdy;
    bit         prev_flush;
    bit         prev_inc;
    int         delivered;

    rst = 1'b1; i_pc = '0; i_flush = 1'b0; i_imem_ack = 1'b0;
    i_imem_data = '0; i_ins_ready = 1'b0;
    mem_rand = 1'b0; mem_lat = 0; late_ack = 1'b0; wait_cnt = 0;
    calc_pc = '0; calc_start = '0;

    // Basic fetch of 0x10, decoder stalled
    mem_lat = 0;
    do_reset(8'h10);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_inc", o_pc_inc, 1);
    chk("t1_req_lo", o_imem_req, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_req", o_imem_req, 1);
    chk("t1_addr", o_imem_addr, 8'h10);
    chk("t1_inc_lo", o_pc_inc, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_valid", o_ins_valid, 1);
    chk("t1_ins", o_ins, 8'hA5);
    chk("t1_ins_pc", o_ins_pc, 8'h10);
    chk("t2_prefetch_inc", o_pc_inc, PF);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_req2", o_imem_req, PF);
    if (PF) chk("t2_addr2", o_imem_addr, 8'h11);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_req_idle", o_imem_req, 0);
    chk("t2_no_inc", o_pc_inc, 0);
    chk("t2_hold_pc", o_ins_pc, 8'h10);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_no_third", o_imem_req, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_pop_valid", o_ins_valid, 1);
    chk("t2_pop_pc", o_ins_pc, 8'h10);
    chk("t2_pop_inc", o_pc_inc, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_after_pop_inc", o_pc_inc, 1);
    chk("t2_after_pop_valid", o_ins_valid, PF);
    if (PF) chk("t2_after_pop_pc", o_ins_pc, 8'h11);

    // Flush to 0x40 while the 0x12 request waits
    mem_lat = 3;
    do_reset(8'h12);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_inc", o_pc_inc, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_addr", o_imem_addr, 8'h12);
    cyc(1'b0, 1'b1, 8'h40, 1'b1);
    chk("t3_flush_inc", o_pc_inc, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_disc_req", o_imem_req, 1);
    chk("t3_disc_addr", o_imem_addr, 8'h12);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_late_ack_inc", o_pc_inc, 0);
    mem_lat = 0;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_dropped", o_ins_valid, 0);
    chk("t3_tgt_inc", o_pc_inc, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_tgt_req", o_imem_req, 1);
    chk("t3_tgt_addr", o_imem_addr, 8'h40);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_deliv_pc", o_ins_pc, 8'h40);
    chk("t3_deliv_ins", o_ins, memf(8'h40));

    // Flush coincident with ack
    mem_lat = 1;
    do_reset(8'h20);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_addr", o_imem_addr, 8'h20);
    cyc(1'b0, 1'b1, 8'h50, 1'b1);
    chk("t4_ack_seen", i_imem_ack, 1);
    mem_lat = 0;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_empty", o_ins_valid, 0);
    chk("t4_tgt_inc", o_pc_inc, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_tgt_addr", o_imem_addr, 8'h50);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_deliv_pc", o_ins_pc, 8'h50);

    // Flush in IDLE with a launch possible
    mem_lat = 0;
    do_reset(8'h30);
    cyc(1'b0, 1'b1, 8'h60, 1'b1);
    chk("t5_inc", o_pc_inc, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_addr", o_imem_addr, 8'h60);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_deliv_pc", o_ins_pc, 8'h60);
    chk("t5_deliv_ins", o_ins, memf(8'h60));

    // Reset mid-request, then a stray ack
    mem_lat = 3;
    do_reset(8'h70);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_req", o_imem_req, 1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t6_rst_inc", o_pc_inc, 0);
    mem_lat  = 0;
    late_ack = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    late_ack = 1'b0;
    chk("t6_req_dropped", o_imem_req, 0);
    chk("t6_valid", o_ins_valid, 0);
    chk("t6_relaunch", o_pc_inc, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_addr", o_imem_addr, 8'h70);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_ins", o_ins, memf(8'h70));
    chk("t6_ins_pc", o_ins_pc, 8'h70);

    // Randomized run against the program-order model
    mem_rand = 1'b1;
    exp_pc = 8'($urandom);
    do_reset(exp_pc);
    prev_flush = 1'b0;
    prev_inc   = 1'b0;
    delivered  = 0;
    for (int n = 0; n < 2000; n++) begin
      fl  = ($urandom_range(0, 11) == 0);
      tgt = 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      cyc(1'b0, fl, tgt, rdy);
      if (prev_flush) chk("rnd_valid_after_flush", o_ins_valid, 0);
      if (prev_inc)   chk("rnd_req_after_inc", o_imem_req, 1);
      if (o_ins_valid) begin
        chk("rnd_head_pc", o_ins_pc, exp_pc);
        chk("rnd_head_ins", o_ins, memf(exp_pc));
      end
      if (fl) exp_pc = tgt;
      else if (o_ins_valid && rdy) begin
        exp_pc = exp_pc + 8'h01;
        delivered++;
      end
      prev_flush = fl;
      prev_inc   = o_pc_inc;
    end
    chk("rnd_liveness", (delivered > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetcher.md
# instruction_fetcher

Instruction fetch stage directly downstream of the PC address calculator. Takes the current PC, issues a single-outstanding read to instruction memory, buffers the returned instruction with its address, and hands it to the decoder over a valid/ready handshake. It drives the calculator's PC-advance strobe on every launched fetch and drops in-flight or buffered instructions on a jump flush.

## Interface
- DATA_WIDTH, 8: PC/address width; equals the global data width.
- INS_WIDTH, 8: instruction word width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- i_pc  input  DATA_WIDTH  current PC from the address calculator; during a jump cycle this is the jump target.
- i_flush  input  1  jump strobe; same signal as the calculator's jump enable.
- o_pc_inc  output  1  PC-advance strobe to the calculator, combinational, high in the launch cycle.
- o_imem_req  output  1  memory read request, registered.
- o_imem_addr  output  DATA_WIDTH  read address, registered, stable while o_imem_req is high.
- i_imem_ack  input  1  read complete; i_imem_data is valid in this cycle.
- i_imem_data  input  INS_WIDTH  returned instruction.
- o_ins_valid  output  1  buffer head valid to the decoder.
- o_ins  output  INS_WIDTH  head instruction.
- o_ins_pc  output  DATA_WIDTH  address of the head instruction.
- i_ins_ready  input  1  decoder accepts the head; pop occurs when valid && ready.

## Operation
- The FSM has three states.
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DISCARD: request outstanding, result to be dropped.
- Launch occurs in IDLE when count < DEPTH. Launch is permitted in the cycle i_flush is high.
  - Launch address is r_tgt if tgt_valid, else i_pc.
  - o_pc_inc = launch && !tgt_valid.
  - On launch, r_addr takes the launch address, tgt_valid is cleared, and the state moves to REQ.
  - o_pc_inc high during a flush cycle is allowed, because the calculator ORs it with the jump enable and advances only once.
- REQ with i_imem_ack and no flush: push {r_addr, i_imem_data}, then go to IDLE.
- Flush rules:
  - The buffer is cleared at the flush edge.
  - REQ + flush + ack: drop the data and go to IDLE.
  - REQ + flush, no ack: go to DISCARD.
  - IDLE + flush with no launch in that cycle: r_tgt ← i_pc, tgt_valid ← 1.
  - In REQ or DISCARD, flush also captures r_tgt/tgt_valid, and the latest flush wins.
- DISCARD + ack: drop the data and go to IDLE. o_pc_inc never accompanies a dropped result.
- Buffer behaviour:
  - Circular buffer of DEPTH entries; count is 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible because a launch reserves a slot and at most one request is outstanding.
- Reset:
  - state = IDLE, count = 0, tgt_valid = 0.
  - All outputs are 0: o_imem_req, o_imem_addr, o_ins_valid, o_ins, o_ins_pc, o_pc_inc.
  - Reset mid-request abandons the request. Memory must tolerate a deasserted req without an ack.

## Timing
- Launch in cycle n gives o_imem_req = 1 and o_imem_addr valid from n+1 until the ack cycle, inclusive.
- Ack in cycle m: the push occurs at the m edge. o_ins_valid rises in m+1 if the buffer was empty.
- The earliest next launch is m+1. With a 1-cycle memory, throughput is one instruction per 2 cycles.
- Flush in cycle f gives o_ins_valid = 0 in f+1.
- o_ins and o_ins_pc are held stable while valid && !ready.

## Configuration
- INS_PREFETCH_EN defined: DEPTH = 2. The next fetch launches while one instruction waits for the decoder.
- INS_PREFETCH_EN undefined: DEPTH = 1. A launch requires an empty buffer, so a fetch starts only after the decoder pops.

## Structure
- Shared package/define file holds:
  - FSM state encodings IF_IDLE, IF_REQ, IF_DISCARD (2 bits).
  - IF_DEPTH, derived from INS_PREFETCH_EN.
- One sub-module: ins_buffer. It holds the {pc, ins} storage, pointers, count, and the push/pop/clear ports.

## Test plan
- Reset, then i_pc = 0x10 with a 1-cycle-ack memory returning 0xA5: o_pc_inc pulses once, req with addr 0x10, then o_ins_valid with o_ins = 0xA5 and o_ins_pc = 0x10, all outputs 0 during reset.
- Decoder ready held low with INS_PREFETCH_EN defined: the second fetch for 0x11 completes and count = 2, no third req. With the macro undefined, no second req is issued until the pop.
- Flush to 0x40 while a req for 0x12 waits 3 cycles for ack: the returned 0x12 data is dropped and no o_pc_inc accompanies it. The next req uses addr 0x40 with o_pc_inc = 0, and the delivered o_ins_pc = 0x40.
- Flush in the same cycle as ack: the data is dropped, the buffer is empty next cycle, and the target is fetched next.
- Flush in IDLE with a launch possible: the request uses i_pc = target in the same cycle.
- Synchronous reset asserted while o_imem_req = 1: next cycle req = 0, o_ins_valid = 0, state IDLE. A late ack after reset is ignored.
